wb_commit_unit: RTL and testbench

- Parametrised next-generation writeback/commit stage of the 5-stage LoongArch pipeline; sits after the memory stage.
- Retires one instruction per cycle.
- Writes the register file through a shared write port that can back-pressure.
- Resolves multi-source exceptions by fixed priority, raises excp/ertn flush pulses, and keeps a retired-instruction counter.

---
 rtl/wb_commit_unit.sv | 186 ++++++++++++++++++
 tb/tb_wb_commit_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
// ---------------------------------------------------------------------------
// wb_commit_unit
//
// Writeback / commit stage of the 5-stage LoongArch pipeline.
// It holds one instruction latched from the memory stage and retires it.
// It writes the GPR file through a shared write port that may refuse a write.
// It resolves simultaneous exception requests by fixed priority, where index 0
// has the highest priority.
// It raises single-cycle exception and ertn flush pulses and counts retired
// instructions.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   me_valid            ME offers an instruction this cycle
//   wb_allow_in         WB accepts the offered instruction this cycle
//   me_pc/gr_we/dest/result/ertn/exc_req/exc_code
//                       fields of the offered instruction; exc_code slice i is
//                       {ecode[5:0], esubcode[8:0]} at bits [15i+14:15i]
//   rf_wready           the shared RF write port grants a write this cycle
//   rf_we/waddr/wdata   RF write port (single pulse on the grant cycle)
//   wb_dest             pending destination for hazard detection (0 = none)
//   wb_fwd_data         stage result for forwarding
//   excp_flush          exception commit pulse
//   ertn_flush          ertn commit pulse
//   wb_ecode/esubcode   code of the committing exception, else 0
//   wb_pc               PC of the instruction held in WB
//   retire_cnt          retired-instruction counter (wraps)
//   debug_wb_rf_*       debug mirror of the RF write port
// ---------------------------------------------------------------------------
module wb_commit_unit #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_EXC = 4,
    parameter int CNT_W   = 64
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   me_valid,
    output logic                   wb_allow_in,
    input  logic [PC_W-1:0]        me_pc,
    input  logic                   me_gr_we,
    input  logic [ADDR_W-1:0]      me_dest,
    input  logic [DATA_W-1:0]      me_result,
    input  logic                   me_ertn,
    input  logic [NUM_EXC-1:0]     me_exc_req,
    input  logic [NUM_EXC*15-1:0]  me_exc_code,

    input  logic                   rf_wready,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,

    output logic [ADDR_W-1:0]      wb_dest,
    output logic [DATA_W-1:0]      wb_fwd_data,

    output logic                   excp_flush,
    output logic                   ertn_flush,
    output logic [5:0]             wb_ecode,
    output logic [8:0]             wb_esubcode,
    output logic [PC_W-1:0]        wb_pc,

    output logic [CNT_W-1:0]       retire_cnt,

    output logic [3:0]             debug_wb_rf_we,
    output logic [ADDR_W-1:0]      debug_wb_rf_wnum,
    output logic [DATA_W-1:0]      debug_wb_rf_wdata
);

    // Priority encoder over the exception sources.
    // The lowest set request index selects its {ecode, esubcode} slice.
    // The loop scans from the top down, so lower indices overwrite higher ones.
    function automatic logic [14:0] pick_exc_code(
        input logic [NUM_EXC-1:0]    req,
        input logic [NUM_EXC*15-1:0] codes
    );
        logic [14:0] sel;
        sel = 15'd0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = codes[15*i +: 15];
            end
        end
        return sel;
    endfunction

    logic                   vld_p0;
    logic [PC_W-1:0]        pc_p0;
    logic                   gr_we_p0;
    logic [ADDR_W-1:0]      dest_p0;
    logic [DATA_W-1:0]      result_p0;
    logic                   ertn_p0;
    logic [NUM_EXC-1:0]     exc_req_p0;
    logic [NUM_EXC*15-1:0]  exc_code_p0;
    logic [CNT_W-1:0]       cnt_q;

    logic                   exc_any;
    logic                   we_eff;
    logic                   ready_go;
    logic                   commit;
    logic                   flush_now;
    logic                   latch;
    logic [14:0]            exc_sel;

    // ---- ME -> WB stage boundary ----
    // All latched fields are cleared on reset so that the outputs read back as
    // zero afterwards.
    // The fields load only when the valid bit also loads a live instruction.
    // An instruction offered in a flush cycle is on the wrong path, so it is
    // dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0      <= 1'b0;
            pc_p0       <= '0;
            gr_we_p0    <= 1'b0;
            dest_p0     <= '0;
            result_p0   <= '0;
            ertn_p0     <= 1'b0;
            exc_req_p0  <= '0;
            exc_code_p0 <= '0;
        end else begin
            if (flush_now) begin
                vld_p0 <= 1'b0;
            end else if (wb_allow_in) begin
                vld_p0 <= me_valid;
            end
            if (latch) begin
                pc_p0       <= me_pc;
                gr_we_p0    <= me_gr_we;
                dest_p0     <= me_dest;
                result_p0   <= me_result;
                ertn_p0     <= me_ertn;
                exc_req_p0  <= me_exc_req;
                exc_code_p0 <= me_exc_code;
            end
        end
    end

    // An excepting instruction never writes the RF, even when gr_we is set.
    // Only a real pending write can stall on the shared port.
    assign exc_any     = |exc_req_p0;
    assign we_eff      = vld_p0 & gr_we_p0 & ~exc_any;
    assign ready_go    = ~we_eff | rf_wready;
    assign wb_allow_in = ~vld_p0 | ready_go;
    assign commit      = vld_p0 & ready_go;
    assign flush_now   = excp_flush | ertn_flush;
    assign latch       = me_valid & wb_allow_in & ~flush_now;

    // The write fires only in the grant cycle.
    // In that same cycle commit lets the stage take the next instruction, so
    // the write cannot repeat.
    assign rf_we       = we_eff & rf_wready;
    assign rf_waddr    = dest_p0;
    assign rf_wdata    = result_p0;

    assign wb_dest     = we_eff ? dest_p0 : '0;
    assign wb_fwd_data = result_p0;
    assign wb_pc       = pc_p0;

    // An exception takes priority over ertn when both are set.
    assign excp_flush  = commit & exc_any;
    assign ertn_flush  = commit & ertn_p0 & ~exc_any;

    assign exc_sel     = (vld_p0 && exc_any) ? pick_exc_code(exc_req_p0, exc_code_p0)
                                             : 15'd0;
    assign wb_ecode    = exc_sel[14:9];
    assign wb_esubcode = exc_sel[8:0];

    // ---- retirement counter ----
    // An ertn counts as retired. An excepting instruction does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (commit && !exc_any) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign retire_cnt        = cnt_q;

    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_commit_unit.sv
module tb_wb_commit_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        me_valid;
    logic        wb_allow_in;
    logic [31:0] me_pc;
    logic        me_gr_we;
    logic [4:0]  me_dest;
    logic [31:0] me_result;
    logic        me_ertn;
    logic [3:0]  me_exc_req;
    logic [59:0] me_exc_code;
    logic        rf_wready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  wb_dest;
    logic [31:0] wb_fwd_data;
    logic        excp_flush;
    logic        ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [3:0]  retire_cnt;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    // outputs of the wide-counter instance
    logic        wb_allow_in_w;
    logic        rf_we_w;
    logic [4:0]  rf_waddr_w;
    logic [31:0] rf_wdata_w;
    logic [4:0]  wb_dest_w;
    logic [31:0] wb_fwd_data_w;
    logic        excp_flush_w;
    logic        ertn_flush_w;
    logic [5:0]  wb_ecode_w;
    logic [8:0]  wb_esubcode_w;
    logic [31:0] wb_pc_w;
    logic [63:0] retire_cnt_w;
    logic [3:0]  debug_wb_rf_we_w;
    logic [4:0]  debug_wb_rf_wnum_w;
    logic [31:0] debug_wb_rf_wdata_w;

    always #5 clk = ~clk;

    wb_commit_unit #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .me_valid(me_valid), .wb_allow_in(wb_allow_in),
        .me_pc(me_pc), .me_gr_we(me_gr_we), .me_dest(me_dest),
        .me_result(me_result), .me_ertn(me_ertn),
        .me_exc_req(me_exc_req), .me_exc_code(me_exc_code),
        .rf_wready(rf_wready), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .wb_dest(wb_dest), .wb_fwd_data(wb_fwd_data),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .retire_cnt(retire_cnt), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    wb_commit_unit dut_w (
        .clk(clk), .reset(reset),
        .me_valid(me_valid), .wb_allow_in(wb_allow_in_w),
        .me_pc(me_pc), .me_gr_we(me_gr_we), .me_dest(me_dest),
        .me_result(me_result), .me_ertn(me_ertn),
        .me_exc_req(me_exc_req), .me_exc_code(me_exc_code),
        .rf_wready(rf_wready), .rf_we(rf_we_w), .rf_waddr(rf_waddr_w),
        .rf_wdata(rf_wdata_w), .wb_dest(wb_dest_w), .wb_fwd_data(wb_fwd_data_w),
        .excp_flush(excp_flush_w), .ertn_flush(ertn_flush_w),
        .wb_ecode(wb_ecode_w), .wb_esubcode(wb_esubcode_w), .wb_pc(wb_pc_w),
        .retire_cnt(retire_cnt_w), .debug_wb_rf_we(debug_wb_rf_we_w),
        .debug_wb_rf_wnum(debug_wb_rf_wnum_w), .debug_wb_rf_wdata(debug_wb_rf_wdata_w)
    );

    int checks = 0;
    int errors = 0;
    int we_pulses = 0;

    // Behavioural model: the instruction currently sitting in WB plus the
    // number of retirements so far.
    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          we;
        logic [4:0]  dest;
        logic [31:0] res;
        bit          ertn;
        logic [3:0]  req;
        logic [59:0] codes;
    } inst_t;

    inst_t       m;
    logic [63:0] m_cnt;
    bit          m_known = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Derived quantities from the rules
    function automatic bit m_exc();    return m.v && (m.req != 4'd0); endfunction
    function automatic bit m_writes(); return m.v && m.we && (m.req == 4'd0); endfunction
    function automatic bit m_commit(); return m.v && (!m_writes() || rf_wready); endfunction

    function automatic logic [14:0] m_code();
        if (!m_exc()) return 15'd0;
        for (int i = 0; i < 4; i++)
            if (m.req[i]) return m.codes[15*i +: 15];
        return 15'd0;
    endfunction

    task automatic model_check();
        logic [14:0] c;
        if (rf_we === 1'b1) we_pulses++;
        if (!m_known) return;
        c = m_code();
        chk("allow_in",   wb_allow_in, !m.v || !m_writes() || rf_wready);
        chk("rf_we",      rf_we, m_writes() && rf_wready);
        chk("rf_waddr",   rf_waddr, m.dest);
        chk("rf_wdata",   rf_wdata, m.res);
        chk("wb_dest",    wb_dest, m_writes() ? m.dest : 5'd0);
        chk("fwd_data",   wb_fwd_data, m.res);
        chk("excp_flush", excp_flush, m_commit() && m_exc());
        chk("ertn_flush", ertn_flush, m_commit() && m.ertn && !m_exc());
        chk("ecode",      wb_ecode, c[14:9]);
        chk("esubcode",   wb_esubcode, c[8:0]);
        chk("wb_pc",      wb_pc, m.pc);
        chk("retire_cnt", retire_cnt, m_cnt[3:0]);
        chk("retire_cnt_w", retire_cnt_w, m_cnt);
        chk("dbg_we",     debug_wb_rf_we, {4{m_writes() && rf_wready}});
        chk("dbg_wnum",   debug_wb_rf_wnum, m.dest);
        chk("dbg_wdata",  debug_wb_rf_wdata, m.res);
        chk("allow_in_w", wb_allow_in_w, wb_allow_in);
        chk("rf_we_w",    rf_we_w, m_writes() && rf_wready);
    endtask

    task automatic model_update();
        bit flush, allow, commit;
        if (reset) begin
            m = '{default: '0};
            m_cnt = 64'd0;
            m_known = 1;
            return;
        end
        commit = m_commit();
        flush  = commit && (m_exc() || m.ertn);
        allow  = !m.v || !m_writes() || rf_wready;
        if (commit && !m_exc()) m_cnt = m_cnt + 64'd1;
        if (flush) m.v = 0;
        else if (allow) begin
            m.v = me_valid;
            if (me_valid)
                m = '{1'b1, me_pc, me_gr_we, me_dest, me_result, me_ertn, me_exc_req, me_exc_code};
        end
    endtask

    task automatic cycle();
        #1 model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_idle();
        me_valid = 0; me_pc = '0; me_gr_we = 0; me_dest = '0; me_result = '0;
        me_ertn = 0; me_exc_req = '0; me_exc_code = '0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                         input logic [31:0] res, input logic ertn,
                         input logic [3:0] req, input logic [59:0] codes);
        me_valid = 1; me_pc = pc; me_gr_we = we; me_dest = dest; me_result = res;
        me_ertn = ertn; me_exc_req = req; me_exc_code = codes;
    endtask

    initial begin
        logic [59:0] codes;
        int p0;
        set_idle();
        rf_wready = 1;
        reset = 1;
        @(negedge clk);
        cycle();
        cycle();
        reset = 0;
        #1;
        chk("reset_allow", wb_allow_in, 1'b1);
        chk("reset_cnt", retire_cnt_w, 64'd0);
        chk("reset_pc", wb_pc, 32'd0);
        chk("reset_wdata", rf_wdata, 32'd0);

        // 1: four back-to-back writes
        for (int i = 1; i <= 4; i++) begin
            offer(32'h1c00_0000 + 32'(4*i), 1, 5'(i), 32'(8'h11 * i), 0, 4'd0, 60'd0);
            cycle();
        end
        set_idle();
        #1 chk("t1_last_we", rf_we, 1'b1);
        chk("t1_last_data", rf_wdata, 32'h44);
        cycle();
        cycle();
        #1 chk("t1_cnt", retire_cnt_w, 64'd4);

        // 2: stalled write
        offer(32'h1c00_0100, 1, 5'd5, 32'hDEAD, 0, 4'd0, 60'd0);
        cycle();
        set_idle();
        p0 = we_pulses;
        rf_wready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t2_allow", wb_allow_in, 1'b0);
            chk("t2_dest", wb_dest, 5'd5);
            cycle();
        end
        rf_wready = 1;
        #1 chk("t2_we", rf_we, 1'b1);
        chk("t2_data", rf_wdata, 32'hDEAD);
        cycle();
        cycle();
        #1 chk("t2_pulses", 64'(we_pulses - p0), 64'd1);
        chk("t2_cnt", retire_cnt_w, 64'd5);

        // 3: exception priority, wrong-path drop
        codes = '0;
        codes[29:15] = {6'h0B, 9'h000};
        codes[59:45] = {6'h08, 9'h001};
        offer(32'h1c00_0200, 1, 5'd7, 32'h77, 0, 4'b1010, codes);
        cycle();
        offer(32'h1c00_0204, 1, 5'd9, 32'h99, 0, 4'd0, 60'd0);
        #1 chk("t3_excp", excp_flush, 1'b1);
        chk("t3_ecode", wb_ecode, 6'h0B);
        chk("t3_esub", wb_esubcode, 9'h000);
        chk("t3_rf_we", rf_we, 1'b0);
        cycle();
        set_idle();
        #1 chk("t3_drop_dest", wb_dest, 5'd0);
        chk("t3_excp_pulse", excp_flush, 1'b0);
        chk("t3_cnt", retire_cnt_w, 64'd5);
        cycle();

        // 4: ertn, then ertn with exception
        offer(32'h1c00_0300, 0, 5'd0, 32'h0, 1, 4'd0, 60'd0);
        cycle();
        set_idle();
        #1 chk("t4_ertn", ertn_flush, 1'b1);
        chk("t4_excp0", excp_flush, 1'b0);
        cycle();
        #1 chk("t4_cnt", retire_cnt_w, 64'd6);
        codes = '0;
        codes[14:0] = {6'h0D, 9'h003};
        offer(32'h1c00_0304, 0, 5'd0, 32'h0, 1, 4'b0001, codes);
        cycle();
        set_idle();
        #1 chk("t4_excp1", excp_flush, 1'b1);
        chk("t4_ertn1", ertn_flush, 1'b0);
        chk("t4_ecode1", wb_ecode, 6'h0D);
        cycle();
        #1 chk("t4_cnt2", retire_cnt_w, 64'd6);

        // 5: counter wrap at 4 bits
        reset = 1;
        cycle();
        reset = 0;
        for (int i = 0; i < 15; i++) begin
            offer(32'(i * 4), 0, 5'd0, 32'(i), 0, 4'd0, 60'd0);
            cycle();
        end
        set_idle();
        cycle();
        #1 chk("t5_cnt15", retire_cnt, 4'd15);
        offer(32'h40, 0, 5'd0, 32'h0, 0, 4'd0, 60'd0);
        cycle();
        set_idle();
        cycle();
        #1 chk("t5_wrap", retire_cnt, 4'd0);
        chk("t5_wide", retire_cnt_w, 64'd16);

        // 6: reset during stall
        offer(32'h1c00_0400, 1, 5'd3, 32'h33, 0, 4'd0, 60'd0);
        cycle();
        set_idle();
        rf_wready = 0;
        cycle();
        p0 = we_pulses;
        reset = 1;
        cycle();
        reset = 0;
        rf_wready = 1;
        #1 chk("t6_allow", wb_allow_in, 1'b1);
        chk("t6_we", rf_we, 1'b0);
        chk("t6_cnt", retire_cnt_w, 64'd0);
        cycle();
        chk("t6_pulses", 64'(we_pulses - p0), 64'd0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            me_valid = $urandom_range(0, 3) != 0;
            me_pc = $urandom;
            me_gr_we = $urandom_range(0, 3) != 0;
            me_dest = 5'($urandom);
            me_result = $urandom;
            me_ertn = $urandom_range(0, 9) == 0;
            me_exc_req = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0;
            me_exc_code = {28'($urandom), 32'($urandom)};
            rf_wready = $urandom_range(0, 9) < 7;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
